i2c_controller: RTL and testbench

- I2C initiator (controller) that drives single-byte transactions toward the team's I2C peripheral block.
- Each request sends START, then a 7-bit address plus R/W bit, then the slave ACK bit. It then writes one data byte or reads one data byte, then sends STOP.
- Used on-chip and in benches as the bus-side counterpart for peripheral addresses 0x55, 0x2A, 0x3F etc. SDA is open-drain through an output-enable.

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_quarter_timer.sv | 36 +++
 rtl/i2c_controller.sv | 174 +++++++++++++++++
 tb/tb_i2c_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C controller slice.
// Holds the FSM state encoding, R/W bit values and the known peripheral addresses.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WRITE,
        WACK,
        READ,
        RNACK,
        STOP
    } state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [6:0] PERIPH_ADDR_A = 7'h55;
    localparam logic [6:0] PERIPH_ADDR_B = 7'h2A;
    localparam logic [6:0] PERIPH_ADDR_C = 7'h3F;

endpackage

// File: rtl/i2c_quarter_timer.sv
// i2c_quarter_timer: divides clk into SCL quarter periods.
// Ports: clk, reset (sync, active-high), clear_i (restart divider and phase),
//        tick_o (last clk of the current quarter), phase_o (quarter index 0..3).
module i2c_quarter_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    output logic       tick_o,
    output logic [1:0] phase_o
);

    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    phase_q, phase_d;

    always_comb begin
        tick_o  = div_q == DW'(CLK_DIV - 1);
        div_d   = (clear_i || tick_o) ? '0 : div_q + 1'b1;
        phase_d = clear_i ? 2'd0 : tick_o ? phase_q + 2'd1 : phase_q;
        phase_o = phase_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            phase_q <= 2'd0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/i2c_controller.sv
// i2c_controller: single-byte I2C initiator (START, addr+R/W, ACK, one data byte, STOP).
// Ports: clk, reset (sync, active-high); request: start, rw, addr, wdata;
//        status: busy, done, ack_error, rdata; bus: scl_out, sda_oe (1=pull low), sda_in.
module i2c_controller
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic [7:0] rdata,
    output logic       scl_out,
    output logic       sda_oe,
    input  logic       sda_in
);

    state_e     state_q, state_d;
    logic [3:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rw_q, rw_d;
    logic       ack_error_q, ack_error_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       tick, clear;
    logic [1:0] phase;
    logic       sample, bit_end;

    i2c_quarter_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear),
        .tick_o  (tick),
        .phase_o (phase)
    );

    // SDA is sampled on the last clk of Q2; a bit slot ends on the last clk of Q3.
    assign sample  = tick && phase == 2'd2;
    assign bit_end = tick && phase == 2'd3;

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rw_d        = rw_q;
        ack_error_d = ack_error_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        clear       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = START;
                    rw_d        = rw;
                    wdata_d     = wdata;
                    shift_d     = {addr, rw};
                    ack_error_d = 1'b0;
                    busy_d      = 1'b1;
                    clear       = 1'b1;
                end
            end
            START: begin
                // START lasts only two quarters, so the phase is restarted for ADDR.
                if (tick && phase == 2'd1) begin
                    state_d = ADDR;
                    bit_d   = 4'd0;
                    clear   = 1'b1;
                end
            end
            ADDR, WRITE: begin
                if (bit_end) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd7)
                        state_d = state_q == ADDR ? ADDR_ACK : WACK;
                end
            end
            READ: begin
                if (sample)
                    shift_d = {shift_q[6:0], sda_in};
                if (bit_end) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd7)
                        state_d = RNACK;
                end
            end
            ADDR_ACK: begin
                if (sample && sda_in)
                    ack_error_d = 1'b1;
                if (bit_end) begin
                    bit_d   = 4'd0;
                    shift_d = wdata_q;
                    state_d = ack_error_q ? STOP : rw_q == RW_READ ? READ : WRITE;
                end
            end
            WACK, RNACK: begin
                if (state_q == WACK && sample && sda_in)
                    ack_error_d = 1'b1;
                if (bit_end) begin
                    bit_d   = 4'd0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick && phase == 2'd2) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    rdata_d = rw_q == RW_READ ? shift_q : rdata_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus levels are a pure function of registered state, so a reset releases both lines next cycle.
    always_comb begin
        scl_out = 1'b1;
        sda_oe  = 1'b0;
        case (state_q)
            START: sda_oe = phase == 2'd1;
            ADDR, WRITE: begin
                scl_out = phase[1];
                sda_oe  = ~shift_q[7];
            end
            ADDR_ACK, WACK, READ, RNACK: scl_out = phase[1];
            STOP: begin
                scl_out = phase != 2'd0;
                sda_oe  = phase != 2'd2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_q       <= 4'd0;
            shift_q     <= 8'h00;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'h00;
            rw_q        <= 1'b0;
            ack_error_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rw_q        <= rw_d;
            ack_error_q <= ack_error_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ack_error = ack_error_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_i2c_controller.sv
// tb_i2c_controller: directed self-checking bench for i2c_controller with a simple peripheral model.
module tb_i2c_controller;
    import i2c_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = 7'h00;
    logic [7:0] wdata = 8'h00;
    logic       busy, done, ack_error, scl_out, sda_oe, sda_in;
    logic [7:0] rdata;

    logic       drive = 1'b0;
    logic       ack_addr = 1'b1;
    logic       ack_data = 1'b1;
    logic [7:0] rbyte = 8'h00;
    logic [7:0] cap0 = 8'h00;
    logic [7:0] cap1 = 8'h00;
    logic       ack0_line = 1'b0;
    logic       ack1_line = 1'b0;
    logic       scl_p = 1'b1;
    logic       sda_p = 1'b1;
    int         bitn = 0;
    int         stops = 0;
    int         dones = 0;
    int         checks = 0;
    int         errors = 0;

    assign sda_in = !(sda_oe || drive);

    always #5 clk = ~clk;

    i2c_controller #(.CLK_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rw        (rw),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .ack_error (ack_error),
        .rdata     (rdata),
        .scl_out   (scl_out),
        .sda_oe    (sda_oe),
        .sda_in    (sda_in)
    );

    // Peripheral model: counts SCL rising edges since START, captures bytes,
    // and pulls SDA low for ACKs / read data after each SCL falling edge.
    always @(negedge clk) begin
        logic s, l;
        s = scl_out;
        l = sda_in;
        if (done) dones++;
        if (scl_p && s && sda_p && !l) begin
            bitn  = 0;
            drive = 1'b0;
        end else if (scl_p && s && !sda_p && l) begin
            stops++;
        end
        if (!scl_p && s) begin
            if (bitn < 8) cap0 = {cap0[6:0], l};
            else if (bitn == 8) ack0_line = l;
            else if (bitn < 17) cap1 = {cap1[6:0], l};
            else if (bitn == 17) ack1_line = l;
            bitn++;
        end
        if (scl_p && !s)
            drive = (bitn == 8 && ack_addr) ||
                    (bitn == 17 && !cap0[0] && ack_data) ||
                    (bitn >= 9 && bitn < 17 && cap0[0] && !rbyte[16 - bitn]);
        scl_p = s;
        sda_p = l;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction; lat = clk edges from accept to done (0 on timeout).
    task automatic run(input logic [6:0] a, input logic r, input logic [7:0] wd,
                       input int poke, input int rst_at, output int lat);
        lat   = 0;
        addr  = a;
        rw    = r;
        wdata = wd;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
            if (n == poke) begin
                start = 1'b1;
                addr  = 7'h12;
                rw    = RW_READ;
                wdata = 8'h00;
            end
            if (n == poke + 1) start = 1'b0;
            if (n == rst_at) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                chk("rst_scl", scl_out, 1);
                chk("rst_sda_oe", sda_oe, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                break;
            end
        end
    endtask

    initial begin
        int lat, s0, d0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ack_error", ack_error, 0);
        chk("reset_rdata", rdata, 8'h00);
        chk("reset_scl", scl_out, 1);
        chk("reset_sda_oe", sda_oe, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        s0 = stops;
        run(PERIPH_ADDR_A, RW_WRITE, 8'hA5, -1, -1, lat);
        chk("wr_latency", lat, 308);
        chk("wr_ack_error", ack_error, 0);
        chk("wr_addr_byte", cap0, 8'hAA);
        chk("wr_data_byte", cap1, 8'hA5);
        chk("wr_scl_rises", bitn, 19);
        chk("wr_stop", stops - s0, 1);
        chk("wr_busy_end", busy, 0);
        chk("wr_rdata_kept", rdata, 8'h00);
        @(posedge clk);
        #1;

        rbyte = 8'hAA;
        run(PERIPH_ADDR_A, RW_READ, 8'h00, -1, -1, lat);
        chk("rd_latency", lat, 308);
        chk("rd_addr_byte", cap0, 8'hAB);
        chk("rd_rdata", rdata, 8'hAA);
        chk("rd_nack_released", ack1_line, 1);
        chk("rd_ack_error", ack_error, 0);
        @(posedge clk);
        #1;

        ack_addr = 1'b0;
        s0 = stops;
        run(7'h12, RW_WRITE, 8'h77, -1, -1, lat);
        chk("nack_latency", lat, 164);
        chk("nack_ack_error", ack_error, 1);
        chk("nack_addr_byte", cap0, 8'h24);
        chk("nack_scl_rises", bitn, 10);
        chk("nack_stop", stops - s0, 1);
        chk("nack_rdata_kept", rdata, 8'hAA);
        @(posedge clk);
        #1;

        ack_addr = 1'b1;
        ack_data = 1'b0;
        run(PERIPH_ADDR_C, RW_WRITE, 8'h3C, -1, -1, lat);
        chk("dnack_latency", lat, 308);
        chk("dnack_ack_error", ack_error, 1);
        chk("dnack_addr_ack", ack0_line, 0);
        chk("dnack_data_byte", cap1, 8'h3C);
        @(posedge clk);
        #1;

        ack_data = 1'b1;
        d0 = dones;
        run(PERIPH_ADDR_B, RW_WRITE, 8'h96, 50, -1, lat);
        chk("poke_latency", lat, 308);
        chk("poke_ack_error", ack_error, 0);
        chk("poke_addr_byte", cap0, 8'h54);
        chk("poke_data_byte", cap1, 8'h96);
        repeat (20) @(posedge clk);
        #1;
        chk("poke_done_count", dones - d0, 1);
        chk("poke_busy_idle", busy, 0);

        run(PERIPH_ADDR_A, RW_WRITE, 8'h5A, -1, 100, lat);
        d0 = dones;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_no_done", dones - d0, 0);
        chk("rst_idle_busy", busy, 0);
        run(PERIPH_ADDR_A, RW_WRITE, 8'h5A, -1, -1, lat);
        chk("after_rst_latency", lat, 308);
        chk("after_rst_ack_error", ack_error, 0);
        chk("after_rst_addr_byte", cap0, 8'hAA);
        chk("after_rst_data_byte", cap1, 8'h5A);
        chk("after_rst_scl_rises", bitn, 19);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
